axis_uart_tx_arbiter: RTL and testbench
=======================================

AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

Interface
REQ-001 SHALL have parameters: WIDTH, default 8, beat data width; NUM_SRC, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have localparam IDW = clog2(NUM_SRC), minimum 1, the grant index width.
REQ-003 SHALL have ports: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: s_axis_data  input  NUM_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have ports: s_axis_valid  input  NUM_SRC; s_axis_last  input  NUM_SRC; s_axis_ready  output  NUM_SRC  (one bit per source).
REQ-007 SHALL have ports: m_axis_data  output  WIDTH; m_axis_valid  output  1; m_axis_last  output  1; m_axis_ready  input  1  (connects to the FIFO/UART TX slave port).
REQ-008 SHALL have ports: grant_idx  output  IDW  current owner; busy  output  1  high while a packet is owned.

Function
REQ-009 SHALL arbitrate per packet: a grant is held from the first accepted beat until the beat with s_axis_last=1 is accepted (m_axis_valid && m_axis_ready && m_axis_last).
REQ-010 SHALL implement FSM states IDLE, HDR (only with ARB_HDR_EN), and PKT.
REQ-011 IDLE: m_axis_valid=0, all s_axis_ready=0; if any s_axis_valid bit is set, the winner SHALL be registered into grant_idx and the FSM moves to PKT (or HDR) on the next edge, giving one bubble cycle per packet.
REQ-012 Winner selection SHALL be round-robin: search starts at rr_ptr and wraps from NUM_SRC-1 to 0; the first source with valid=1 wins.
REQ-013 rr_ptr SHALL load (grant_idx+1) mod NUM_SRC when the last beat is accepted; rr_ptr SHALL NOT change otherwise.
REQ-014 PKT: m_axis_data/valid/last SHALL be a combinational mux of the granted source, and s_axis_ready[grant_idx] = m_axis_ready; all other ready bits SHALL be 0.
REQ-015 PKT: when the granted source drops valid mid-packet, the grant SHALL be held, m_axis_valid SHALL be 0, and other sources SHALL remain blocked.
REQ-016 On acceptance of the last beat, the FSM SHALL return to IDLE on the next edge; back-to-back packets therefore incur exactly one idle cycle.
REQ-017 busy SHALL be 1 in HDR and PKT and 0 in IDLE; grant_idx SHALL hold its last value in IDLE.
REQ-018 A single-beat packet (valid and last in the first PKT cycle) SHALL complete with the normal one-cycle return to IDLE.
REQ-019 m_axis_data/last SHALL be don't-care-free: they SHALL be driven 0 whenever m_axis_valid=0.

Reset
REQ-020 On rst=1 at a clock edge: state=IDLE, rr_ptr=0, grant_idx=0, busy=0, m_axis_valid=0, s_axis_ready=0, regardless of any packet in flight.
REQ-021 A packet interrupted by reset SHALL be abandoned; after reset, arbitration SHALL restart from source 0 with no resumption of the interrupted packet.

Configuration
REQ-022 Macro ARB_HDR_EN, when defined, SHALL insert one header beat before each packet: in HDR, m_axis_valid=1, m_axis_data=grant_idx zero-extended to WIDTH, m_axis_last=0, all s_axis_ready=0; the FSM SHALL move to PKT when that beat is accepted.
REQ-023 Without ARB_HDR_EN, the HDR state and its logic SHALL be absent, IDLE SHALL go directly to PKT, and the output stream SHALL be a pure packet interleave.

Verification
REQ-024 Sources 0 and 2 valid simultaneously after reset, each with 3-beat packets (0xA1..0xA3, 0xC1..0xC3), m_axis_ready=1 -> output A1 A2 A3, idle cycle, C1 C2 C3; grant_idx goes 0 then 2.
REQ-025 All 4 sources continuously valid with 1-beat packets -> grant order 0,1,2,3,0; every output beat has last=1; one idle cycle between beats.
REQ-026 Source 1 granted, drops valid after beat 1 for 5 cycles while source 3 is valid -> s_axis_ready[3]=0 throughout, and source 1 completes before source 3 is granted.
REQ-027 m_axis_ready toggles 1,0,1,0 during a 4-beat packet -> no beat lost or duplicated; s_axis_ready mirrors m_axis_ready for the owner only.
REQ-028 rst asserted during beat 2 of a source-2 packet -> next edge gives m_axis_valid=0, busy=0; with sources 1 and 2 valid, the next grant is 1 (rr_ptr=0).
REQ-029 With ARB_HDR_EN, source 3 sends 2-beat 0x55,0x66 -> output 0x03 (last=0), 0x55, 0x66 (last=1).

Source files
------------

// File: rtl/axis_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// axis_uart_tx_arbiter
// Packet-granular round-robin arbiter merging NUM_SRC AXI-Stream sources into
// one AXI-Stream master that feeds a FIFO / UART TX slave port.
//
// Parameters:
//   WIDTH    beat data width
//   NUM_SRC  number of requesters (2..8)
//   IDW      grant index width, clog2(NUM_SRC) with a minimum of 1
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   s_axis_data   source i on bits [i*WIDTH +: WIDTH]
//   s_axis_valid  per-source valid
//   s_axis_last   per-source end-of-packet marker
//   s_axis_ready  per-source ready, only the owner ever sees ready
//   m_axis_*      merged output stream
//   grant_idx     current (or most recent) packet owner
//   busy          high while a packet is owned
//
// Optional feature: define ARB_HDR_EN to emit one header beat carrying the
// grant index ahead of every packet.
// ---------------------------------------------------------------------------
module axis_uart_tx_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned IDW    = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*WIDTH-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]         s_axis_valid,
    input  logic [NUM_SRC-1:0]         s_axis_last,
    output logic [NUM_SRC-1:0]         s_axis_ready,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic [IDW-1:0]             grant_idx,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ARB_HDR_EN
        ST_HDR  = 2'd1,
`endif
        ST_PKT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_idx_q, grant_idx_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    // Per-source data view and the granted source's signals.
    logic [WIDTH-1:0] src_data [NUM_SRC];
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             pkt_done;

    // Round-robin search results.
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW:0]     cand_sum;
    logic [IDW-1:0]   cand_idx;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_data[i] = s_axis_data[i*WIDTH +: WIDTH];
        end
    end

    assign sel_data  = src_data[grant_idx_q];
    assign sel_valid = s_axis_valid[grant_idx_q];
    assign sel_last  = s_axis_last[grant_idx_q];
    assign pkt_done  = (state_q == ST_PKT) && sel_valid && sel_last && m_axis_ready;

    // First valid source starting at rr_ptr, wrapping NUM_SRC-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NUM_SRC)) begin
                cand_sum = cand_sum - (IDW+1)'(NUM_SRC);
            end
            cand_idx = IDW'(cand_sum);
            if (!win_found && s_axis_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Next-state logic: the grant is latched in IDLE, released on the last beat.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_idx_d = win_idx;
`ifdef ARB_HDR_EN
                    state_d     = ST_HDR;
`else
                    state_d     = ST_PKT;
`endif
                end
            end
`ifdef ARB_HDR_EN
            ST_HDR: begin
                if (m_axis_ready) begin
                    state_d = ST_PKT;
                end
            end
`endif
            ST_PKT: begin
                if (pkt_done) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_idx_q == IDW'(NUM_SRC - 1)) ? '0
                                                                  : grant_idx_q + IDW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: data/last are forced to zero whenever valid is low.
    always_comb begin
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
            end
`ifdef ARB_HDR_EN
            ST_HDR: begin
                m_axis_valid = 1'b1;
                m_axis_data  = WIDTH'(grant_idx_q);
            end
`endif
            ST_PKT: begin
                m_axis_valid              = sel_valid;
                m_axis_data               = sel_valid ? sel_data : '0;
                m_axis_last               = sel_valid && sel_last;
                s_axis_ready[grant_idx_q] = m_axis_ready;
            end
            default: begin
            end
        endcase
    end

    assign grant_idx = grant_idx_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_uart_tx_arbiter
// Self-checking bench: queue-driven sources, a packet-level arbitration model
// checked every cycle, plus directed scenarios with fixed expected streams.
// ---------------------------------------------------------------------------
module tb_axis_uart_tx_arbiter;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
`ifdef ARB_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [N*W-1:0]     s_axis_data;
    logic [N-1:0]       s_axis_valid;
    logic [N-1:0]       s_axis_last;
    logic [N-1:0]       s_axis_ready;
    logic [W-1:0]       m_axis_data;
    logic               m_axis_valid;
    logic               m_axis_last;
    logic               m_axis_ready;
    logic [IDW-1:0]     grant_idx;
    logic               busy;

    always #5 clk = ~clk;

    axis_uart_tx_arbiter #(.WIDTH(W), .NUM_SRC(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .grant_idx    (grant_idx),
        .busy         (busy)
    );

    // Source packet queues: bit 8 = last, bits 7:0 = data.
    logic [8:0] q [N][$];
    logic [8:0] out_log [$];
    logic [8:0] exp_d [$];
    int         grant_log [$];
    int         exp_g [$];

    // Stimulus controls.
    bit [N-1:0] allow;
    int         vprob;
    bit         rdy_rand;
    bit         rdy_fix;
    bit         rst_ctl;
    bit         prev_busy;

    // Reference model: ownership, header pending, owner and rr pointer.
    bit mb, mh;
    int mg, mp;

    int n_checks, n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    // One clock: drive at negedge, check at negedge+1, advance the model.
    task automatic step();
        logic [N-1:0] v;
        logic         ev, el;
        logic [W-1:0] ed;
        logic [N-1:0] er;
        int           w;
        @(negedge clk);
        rst = rst_ctl;
        for (int i = 0; i < N; i++) begin
            v[i] = allow[i] && (q[i].size() > 0) && ($urandom_range(99) < vprob);
            if (v[i]) begin
                s_axis_data[i*W +: W] = q[i][0][7:0];
                s_axis_last[i]        = q[i][0][8];
            end else begin
                s_axis_data[i*W +: W] = W'($urandom);
                s_axis_last[i]        = 1'($urandom);
            end
        end
        s_axis_valid = v;
        m_axis_ready = rdy_rand ? 1'($urandom_range(1)) : rdy_fix;
        #1;
        ev = 1'b0; ed = '0; el = 1'b0; er = '0;
        if (mb && mh) begin
            ev = 1'b1;
            ed = W'(mg);
        end else if (mb) begin
            if (v[mg]) begin
                ev = 1'b1;
                ed = q[mg][0][7:0];
                el = q[mg][0][8];
            end
            er = m_axis_ready ? (N'(1) << mg) : '0;
        end
        check("busy", 32'(busy), 32'(mb));
        check("grant_idx", 32'(grant_idx), 32'(mg));
        check("m_valid", 32'(m_axis_valid), 32'(ev));
        check("m_data", 32'(m_axis_data), 32'(ed));
        check("m_last", 32'(m_axis_last), 32'(el));
        check("s_ready", 32'(s_axis_ready), 32'(er));
        if (busy && !prev_busy) grant_log.push_back(int'(grant_idx));
        prev_busy = busy;
        if (m_axis_valid && m_axis_ready) out_log.push_back({m_axis_last, m_axis_data});
        if (rst_ctl) begin
            mb = 1'b0; mh = 1'b0; mg = 0; mp = 0;
        end else if (!mb) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && v[(mp + k) % N]) w = (mp + k) % N;
            end
            if (w >= 0) begin
                mb = 1'b1; mh = HDR; mg = w;
            end
        end else if (mh) begin
            if (m_axis_ready) mh = 1'b0;
        end else if (v[mg] && m_axis_ready) begin
            if (q[mg][0][8]) begin
                mb = 1'b0;
                mp = (mg + 1) % N;
            end
            void'(q[mg].pop_front());
        end
    endtask

    task automatic do_reset();
        rst_ctl = 1'b1;
        step();
        rst_ctl = 1'b0;
        out_log.delete();
        grant_log.delete();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((pending() > 0 || mb) && k < budget) begin
            step();
            k++;
        end
        check("drain", 32'(pending() + int'(mb)), 32'd0);
    endtask

    task automatic cmp_grants(input string tag);
        check({tag, "_gcnt"}, 32'(grant_log.size()), 32'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
            check({tag, "_grant"}, 32'(grant_log[i]), 32'(exp_g[i]));
    endtask

    task automatic cmp_out(input string tag);
        check({tag, "_bcnt"}, 32'(out_log.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < out_log.size(); i++)
            check({tag, "_beat"}, 32'(out_log[i]), 32'(exp_d[i]));
    endtask

    initial begin
        int beats_in;
        int nb;
        n_checks = 0; n_pass = 0;
        mb = 1'b0; mh = 1'b0; mg = 0; mp = 0;
        allow = '1; vprob = 100; rdy_rand = 1'b0; rdy_fix = 1'b1;
        rst_ctl = 1'b0; prev_busy = 1'b0;
        rst = 1'b1; s_axis_valid = '0; s_axis_last = '0; s_axis_data = '0;
        m_axis_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state with no requests.
        repeat (2) step();

        // Sources 0 and 2 together: 0 first, then 2 after one idle cycle.
        do_reset();
        q[0] = {9'h0A1, 9'h0A2, 9'h1A3};
        q[2] = {9'h0C1, 9'h0C2, 9'h1C3};
        drain(30);
        exp_g = {0, 2};
        exp_d = {9'h0A1, 9'h0A2, 9'h1A3, 9'h0C1, 9'h0C2, 9'h1C3};
`ifndef ARB_HDR_EN
        cmp_grants("two_src");
        cmp_out("two_src");
`endif

        // All sources, single-beat packets: rotation 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < N; i++) q[i] = {9'h110 + 9'(i), 9'h120 + 9'(i)};
        drain(40);
        exp_g = {0, 1, 2, 3, 0, 1, 2, 3};
        exp_d = {9'h110, 9'h111, 9'h112, 9'h113, 9'h120, 9'h121, 9'h122, 9'h123};
`ifndef ARB_HDR_EN
        cmp_grants("rr");
        cmp_out("rr");
`endif

        // Owner stalls mid-packet; source 3 stays blocked.
        do_reset();
        q[1] = {9'h071, 9'h072, 9'h173};
        q[3] = {9'h091, 9'h192};
        step();
        step();
`ifdef ARB_HDR_EN
        step();
`endif
        allow[1] = 1'b0;
        repeat (5) begin
            step();
            check("stall_rdy3", 32'(s_axis_ready[3]), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_grant", 32'(grant_idx), 32'd1);
        end
        allow[1] = 1'b1;
        drain(40);
        exp_g = {1, 3};
        exp_d = {9'h071, 9'h072, 9'h173, 9'h091, 9'h192};
`ifndef ARB_HDR_EN
        cmp_grants("stall");
        cmp_out("stall");
`endif

        // Output backpressure toggling during a 4-beat packet.
        do_reset();
        q[0] = {9'h031, 9'h032, 9'h033, 9'h134};
        nb = 0;
        while ((pending() > 0 || mb) && nb < 30) begin
            rdy_fix = ~nb[0];
            step();
            nb++;
        end
        rdy_fix = 1'b1;
        check("bp_drain", 32'(pending() + int'(mb)), 32'd0);
        exp_d = {9'h031, 9'h032, 9'h033, 9'h134};
`ifndef ARB_HDR_EN
        cmp_out("bp");
`endif

        // Reset during beat 2 of a source-2 packet abandons it.
        do_reset();
        q[2] = {9'h041, 9'h042, 9'h043, 9'h144};
        step();
        step();
`ifdef ARB_HDR_EN
        step();
`endif
        rst_ctl = 1'b1;
        step();
        rst_ctl = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        q[1] = {9'h151};
        q[2] = {9'h161};
        grant_log.delete();
        out_log.delete();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(m_axis_valid), 32'd0);
        drain(30);
        exp_g = {1, 2};
        exp_d = {9'h151, 9'h161};
        cmp_grants("rst");
`ifndef ARB_HDR_EN
        cmp_out("rst");
`endif

`ifdef ARB_HDR_EN
        // Header beat carries the grant index ahead of the payload.
        do_reset();
        q[3] = {9'h055, 9'h166};
        drain(20);
        exp_d = {9'h003, 9'h055, 9'h166};
        cmp_out("hdr");
`endif

        // Randomized packets, random gaps and backpressure.
        do_reset();
        beats_in = 0;
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 6; p++) begin
                nb = int'($urandom_range(4, 1));
                for (int b = 0; b < nb; b++)
                    q[i].push_back({(b == nb - 1), 8'($urandom)});
                beats_in += nb + int'(HDR);
            end
        end
        vprob = 70;
        rdy_rand = 1'b1;
        drain(6000);
        check("rand_beats", 32'(out_log.size()), 32'(beats_in));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
